// File: rtl/smem_pkg.sv
// smem_pkg: shared row geometry and feeder state encoding for the SMEM row path
package smem_pkg;
    localparam int ROW_BYTES        = 256;
    localparam int SEGMENTS_PER_ROW = 4;
    localparam int ENTRIES_PER_ROW  = 64;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} feeder_state_t;
endpackage

// File: rtl/smem_row_feeder_if.sv
// smem_row_feeder_if: input stream and writer-facing row bus of the row feeder
interface smem_row_feeder_if #(parameter int DW = 512);
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] smem_data0;
    logic [DW-1:0] smem_data1;
    logic [DW-1:0] smem_data2;
    logic [DW-1:0] smem_data3;
    logic [31:0]   row_index;
    logic          start;
    logic          writer_ready;
    logic          writer_done;
    modport master (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, writer_ready, writer_done,
        output s_axis_tready, smem_data0, smem_data1, smem_data2, smem_data3, row_index, start
    );
    modport slave (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid, writer_ready, writer_done,
        input  s_axis_tready, smem_data0, smem_data1, smem_data2, smem_data3, row_index, start
    );
endinterface

// File: rtl/smem_row_buffer.sv
// smem_row_buffer: one 4-segment row store with full flag and latched row index
module smem_row_buffer import smem_pkg::*; #(parameter int DW = 512) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en_i,
    input  logic [1:0]                           seg_i,
    input  logic [DW-1:0]                        wdata_i,
    input  logic                                 set_full_i,
    input  logic                                 clr_full_i,
    input  logic [31:0]                          row_idx_i,
    output logic [SEGMENTS_PER_ROW-1:0][DW-1:0]  data_o,
    output logic                                 full_o,
    output logic [31:0]                          row_idx_o
);
    logic [SEGMENTS_PER_ROW-1:0][DW-1:0] data_q, data_d;
    logic                                full_q, full_d;
    logic [31:0]                         idx_q, idx_d;

    // Segment write, full set/clear and index capture on the completing beat
    always_comb begin
        data_d = data_q;
        if (wr_en_i) data_d[seg_i] = wdata_i;
        full_d = set_full_i ? 1'b1 : clr_full_i ? 1'b0 : full_q;
        idx_d  = set_full_i ? row_idx_i : idx_q;
    end

    // Storage registers, emptied and zeroed by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end

    assign data_o    = data_q;
    assign full_o    = full_q;
    assign row_idx_o = idx_q;
endmodule

// File: rtl/smem_row_feeder.sv
// smem_row_feeder: packs 4-beat stream rows into ping-pong buffers and issues them to the SMEM row writer
module smem_row_feeder import smem_pkg::*; #(parameter int DW = 512) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cfg_first_row,
    input  logic [31:0]       cfg_row_count,
    input  logic              go,
    output logic              busy,
    output logic              all_done,
    output logic              error,
    smem_row_feeder_if.master bus
);
    localparam int BEATS_PER_ROW = SEGMENTS_PER_ROW;

    feeder_state_t state_q, state_d;
    logic [31:0] first_q, first_d, count_q, count_d, loaded_q, loaded_d, issued_q, issued_d;
    logic [1:0]  beat_q, beat_d;
    logic        wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, in_flight_q, in_flight_d;
    logic        start_q, start_d, all_done_q, all_done_d, error_q, error_d;
    logic [1:0]  full, wr_en, set_full, clr_full;
    logic [1:0][31:0] row_idx;
    logic [1:0][SEGMENTS_PER_ROW-1:0][DW-1:0] data;
    logic        hs, last_beat, issue, release_row;

    assign bus.s_axis_tready = (state_q == RUN) & !full[wr_sel_q] & (loaded_q < count_q);
    assign hs          = bus.s_axis_tvalid & bus.s_axis_tready;
    assign last_beat   = beat_q == 2'(BEATS_PER_ROW - 1);
    assign issue       = (state_q == RUN) & full[rd_sel_q] & !in_flight_q & bus.writer_ready & !start_q;
    assign release_row = in_flight_q & bus.writer_ready & !start_q;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        assign wr_en[i]    = hs & (wr_sel_q == 1'(i));
        assign set_full[i] = wr_en[i] & last_beat;
        assign clr_full[i] = release_row & (rd_sel_q == 1'(i));
        smem_row_buffer #(.DW(DW)) u_buf (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (wr_en[i]),
            .seg_i      (beat_q),
            .wdata_i    (bus.s_axis_tdata),
            .set_full_i (set_full[i]),
            .clr_full_i (clr_full[i]),
            .row_idx_i  (first_q + loaded_q),
            .data_o     (data[i]),
            .full_o     (full[i]),
            .row_idx_o  (row_idx[i])
        );
    end

    assign bus.smem_data0 = data[rd_sel_q][0];
    assign bus.smem_data1 = data[rd_sel_q][1];
    assign bus.smem_data2 = data[rd_sel_q][2];
    assign bus.smem_data3 = data[rd_sel_q][3];
    assign bus.row_index  = row_idx[rd_sel_q];
    assign bus.start      = start_q;
    assign busy           = state_q != IDLE;
    assign all_done       = all_done_q;
    assign error          = error_q;

    // Job FSM plus fill, issue and release bookkeeping
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        count_d     = count_q;
        loaded_d    = loaded_q;
        issued_d    = issued_q;
        beat_d      = beat_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        in_flight_d = in_flight_q;
        start_d     = issue;
        all_done_d  = all_done_q;
        error_d     = error_q;
        if (hs) begin
            beat_d = beat_q + 2'd1;
            if (bus.s_axis_tlast != last_beat) error_d = 1'b1;
            if (last_beat) begin
                loaded_d = loaded_q + 32'd1;
                wr_sel_d = !wr_sel_q;
            end
        end
        if (issue) begin
            in_flight_d = 1'b1;
            issued_d    = issued_q + 32'd1;
        end
        if (release_row) begin
            in_flight_d = 1'b0;
            rd_sel_d    = !rd_sel_q;
        end
        case (state_q)
            IDLE: if (go) begin
                first_d    = cfg_first_row;
                count_d    = cfg_row_count;
                loaded_d   = '0;
                issued_d   = '0;
                beat_d     = '0;
                error_d    = 1'b0;
                all_done_d = 1'b0;
                state_d    = (cfg_row_count == 32'd0) ? DRAIN : RUN;
            end
            RUN: if (issued_q == count_q && !in_flight_q) state_d = DRAIN;
            DRAIN: if (bus.writer_done) begin
                state_d    = IDLE;
                all_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any partial row and empties both buffers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            first_q     <= '0;
            count_q     <= '0;
            loaded_q    <= '0;
            issued_q    <= '0;
            beat_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            in_flight_q <= 1'b0;
            start_q     <= 1'b0;
            all_done_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            count_q     <= count_d;
            loaded_q    <= loaded_d;
            issued_q    <= issued_d;
            beat_q      <= beat_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            in_flight_q <= in_flight_d;
            start_q     <= start_d;
            all_done_q  <= all_done_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_smem_row_feeder.sv
// tb_smem_row_feeder: directed scoreboard bench for the SMEM row feeder
module tb_smem_row_feeder;
    localparam int DW   = 512;
    localparam int WLAT = 20;

    typedef struct {
        logic [31:0]     idx;
        logic [4*DW-1:0] data;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [31:0] cfg_first_row = '0;
    logic [31:0] cfg_row_count = '0;
    logic        busy, all_done, error;
    logic        w_ready, w_done;
    int          w_cnt, w_lag;
    int          checks = 0, errors = 0, starts = 0, beats = 0, tag = 0;
    bit          hold = 1'b0, stall = 1'b0, tb_fl = 1'b0;
    logic [31:0]     cap_idx;
    logic [4*DW-1:0] cap_data;
    row_t        exp_q[$];
    row_t        mon_e;

    smem_row_feeder_if #(.DW(DW)) bus();

    smem_row_feeder #(.DW(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_first_row (cfg_first_row),
        .cfg_row_count (cfg_row_count),
        .go            (go),
        .busy          (busy),
        .all_done      (all_done),
        .error         (error),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.writer_ready = w_ready;
    assign bus.writer_done  = w_done;

    // Writer model: busy WLAT cycles after start, done rises a few cycles after ready returns
    always @(posedge clk) begin
        if (reset) begin
            w_ready <= 1'b1;
            w_done  <= 1'b0;
            w_cnt   <= 0;
            w_lag   <= 0;
        end else if (bus.start) begin
            w_ready <= 1'b0;
            w_done  <= 1'b0;
            w_cnt   <= WLAT;
        end else if (!w_ready) begin
            if (w_cnt != 0) w_cnt <= w_cnt - 1;
            else if (!hold) begin
                w_ready <= 1'b1;
                w_lag   <= 4;
            end
        end else if (w_lag != 0) begin
            w_lag <= w_lag - 1;
            if (w_lag == 1) w_done <= 1'b1;
        end
    end

    task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag_s, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag_s, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed[63:0]=%h expected[63:0]=%h", tag_s, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int r, input int b);
        logic [31:0] w;
        w = 32'hA5000000 ^ 32'(r * 16 + b);
        return {(DW/32){w}};
    endfunction

    // Row monitor: scoreboard pop on start, hold check while the writer owns the row
    always @(negedge clk) begin
        if (reset) tb_fl = 1'b0;
        else begin
            if (bus.s_axis_tvalid && bus.s_axis_tready) beats++;
            if (bus.s_axis_tvalid && !bus.s_axis_tready && busy) stall = 1'b1;
            if (bus.start) begin
                starts++;
                cap_data = {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0};
                cap_idx  = bus.row_index;
                if (exp_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("row_index", 64'(cap_idx), 64'(mon_e.idx));
                    chk_row("row_data", cap_data, mon_e.data);
                end
                tb_fl = 1'b1;
            end else if (tb_fl) begin
                chk_row("inflight_data", {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0}, cap_data);
                chk("inflight_idx", 64'(bus.row_index), 64'(cap_idx));
                if (bus.writer_ready) tb_fl = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        if (!bus.s_axis_tvalid) begin
            @(posedge clk);
            #1;
        end
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axis_tready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("beat_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [31:0] idx, input int bad);
        row_t e;
        int t;
        t = tag;
        tag++;
        e.idx  = idx;
        e.data = {mk(t, 3), mk(t, 2), mk(t, 1), mk(t, 0)};
        exp_q.push_back(e);
        for (int b = 0; b < 4; b++) send_beat(mk(t, b), b == 3 || b == bad);
    endtask

    task automatic start_job(input logic [31:0] first, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        cfg_first_row = first;
        cfg_row_count = cnt;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag_s);
        int n;
        n = 0;
        while (!all_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag_s, 64'(all_done), 64'd1);
    endtask

    initial begin
        int s0, b0, n;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", 64'(bus.start), 64'd0);
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_row_index", 64'(bus.row_index), 64'd0);
        chk_row("rst_data", {bus.smem_data3, bus.smem_data2, bus.smem_data1, bus.smem_data0}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        start_job(32'h10, 32'd1);
        send_row(32'h10, -1);
        bus.s_axis_tvalid = 1'b0;
        n = 0;
        while (!w_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("single_done_seen", 64'(w_done), 64'd1);
        chk("single_all_done_pre", 64'(all_done), 64'd0);
        chk("single_busy_pre", 64'(busy), 64'd1);
        @(negedge clk);
        chk("single_all_done", 64'(all_done), 64'd1);
        chk("single_busy_post", 64'(busy), 64'd0);
        chk("single_error", 64'(error), 64'd0);
        chk("single_starts", 64'(starts), 64'd1);
        chk("single_queue", 64'(exp_q.size()), 64'd0);

        stall = 1'b0;
        s0 = starts;
        start_job(32'hFFFFFFFE, 32'd5);
        for (int r = 0; r < 5; r++) send_row(32'hFFFFFFFE + 32'(r), -1);
        bus.s_axis_tvalid = 1'b0;
        wait_done("b2b_done");
        chk("b2b_stall", 64'(stall), 64'd1);
        chk("b2b_starts", 64'(starts - s0), 64'd5);
        chk("b2b_queue", 64'(exp_q.size()), 64'd0);
        chk("b2b_error", 64'(error), 64'd0);

        hold = 1'b1;
        s0 = starts;
        b0 = beats;
        start_job(32'h100, 32'd3);
        fork
            begin
                send_row(32'h100, -1);
                send_row(32'h101, -1);
                send_row(32'h102, -1);
                bus.s_axis_tvalid = 1'b0;
            end
        join_none
        n = 0;
        while (starts == s0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first_start", 64'(starts - s0), 64'd1);
        repeat (200) @(negedge clk);
        chk("bp_beats", 64'(beats - b0), 64'd8);
        chk("bp_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("bp_no_second_start", 64'(starts - s0), 64'd1);
        hold = 1'b0;
        wait fork;
        wait_done("bp_done");
        chk("bp_starts", 64'(starts - s0), 64'd3);
        chk("bp_queue", 64'(exp_q.size()), 64'd0);

        s0 = starts;
        start_job(32'h300, 32'd2);
        send_row(32'h300, 1);
        send_row(32'h301, -1);
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("frame_error_set", 64'(error), 64'd1);
        wait_done("frame_done");
        chk("frame_error_sticky", 64'(error), 64'd1);
        chk("frame_starts", 64'(starts - s0), 64'd2);
        chk("frame_queue", 64'(exp_q.size()), 64'd0);

        s0 = starts;
        start_job(32'h0, 32'd0);
        @(negedge clk);
        chk("zero_error_cleared", 64'(error), 64'd0);
        chk("zero_busy", 64'(busy), 64'd1);
        wait_done("zero_done");
        chk("zero_no_start", 64'(starts - s0), 64'd0);

        s0 = starts;
        start_job(32'h200, 32'd2);
        send_row(32'h200, -1);
        bus.s_axis_tvalid = 1'b0;
        start_job(32'h999, 32'd7);
        send_row(32'h201, -1);
        bus.s_axis_tvalid = 1'b0;
        wait_done("gobusy_done");
        chk("gobusy_starts", 64'(starts - s0), 64'd2);
        chk("gobusy_queue", 64'(exp_q.size()), 64'd0);

        start_job(32'h400, 32'd4);
        send_row(32'h400, -1);
        send_beat(mk(999, 0), 1'b0);
        send_beat(mk(999, 1), 1'b0);
        bus.s_axis_tvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_start", 64'(bus.start), 64'd0);
        chk("mrst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        s0 = starts;
        start_job(32'h55, 32'd1);
        send_row(32'h55, -1);
        bus.s_axis_tvalid = 1'b0;
        wait_done("mrst_done");
        chk("mrst_starts", 64'(starts - s0), 64'd1);
        chk("mrst_queue", 64'(exp_q.size()), 64'd0);
        chk("mrst_error", 64'(error), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
